mem_stage_pipe: RTL and testbench

Parametrised memory stage with M→W pipeline register for the SIMD RISC pipeline. It holds a lane-wide data memory and performs masked per-lane stores and multi-cycle loads with a stall handshake back to earlier stages. It registers load data, ALU result and control into the writeback stage. It replaces the fixed 256-bit, single-cycle memory stage with configurable lane count, lane width, depth and read latency.

---
 rtl/mem_stage_pipe_if.sv | 41 ++++
 rtl/mem_stage_pipe.sv | 92 +++++++++
 tb/tb_mem_stage_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pipe_if.sv
// mem_stage_pipe_if: M-stage inputs, stall and W-stage outputs of the memory stage
interface mem_stage_pipe_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 32,
    parameter int PC_W   = 32
);
    localparam int DW = LANES * LANE_W;

    logic             ValidM;
    logic             RegWriteM;
    logic             ResultSrcM;
    logic             MemWriteM;
    logic [LANES-1:0] LaneMaskM;
    logic [DW-1:0]    ALUResultM;
    logic [DW-1:0]    WriteDataM;
    logic [4:0]       RdM;
    logic [PC_W-1:0]  PCPlus4M;
    logic             StallM;
    logic             ValidW;
    logic             RegWriteW;
    logic             ResultSrcW;
    logic             ErrW;
    logic [DW-1:0]    ReadDataW;
    logic [DW-1:0]    ALUResultW;
    logic [4:0]       RdW;
    logic [PC_W-1:0]  PCPlus4W;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, MemWriteM, LaneMaskM,
               ALUResultM, WriteDataM, RdM, PCPlus4M,
        input  StallM, ValidW, RegWriteW, ResultSrcW, ErrW,
               ReadDataW, ALUResultW, RdW, PCPlus4W
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, MemWriteM, LaneMaskM,
               ALUResultM, WriteDataM, RdM, PCPlus4M,
        output StallM, ValidW, RegWriteW, ResultSrcW, ErrW,
               ReadDataW, ALUResultW, RdW, PCPlus4W
    );
endinterface

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: lane-masked data memory with multi-cycle loads, stall handshake and M->W register
// Optional address bounds checking is enabled by defining MEM_STAGE_BOUNDS_CHECK_EN.
module mem_stage_pipe #(
    parameter int LANES    = 8,
    parameter int LANE_W   = 32,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2,
    parameter int PC_W     = 32
) (
    input logic             clk,
    input logic             rst,
    mem_stage_pipe_if.slave bus
);
    localparam int DW = LANES * LANE_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic          isLoad;
    logic          isStore;
    logic          errM;
    logic          stall;

    assign idx    = bus.ALUResultM[AW-1:0];
    assign isLoad = bus.ValidM & bus.ResultSrcM & ~bus.MemWriteM;

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    assign errM = bus.ValidM & (bus.ResultSrcM | bus.MemWriteM)
                & ((bus.ALUResultM[LANE_W-1:0] >> AW) != '0);
`else
    assign errM = 1'b0;
`endif

    assign isStore    = bus.ValidM & bus.MemWriteM & (state == IDLE) & ~errM & ~rst;
    assign stall      = ((state == IDLE) & isLoad & (READ_LAT > 1)) | ((state == BUSY) & (cnt != '0));
    assign bus.StallM = stall;

    // Load sequencer: cnt holds the stall cycles still owed after the presentation cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (isLoad && READ_LAT > 1) begin
                state <= BUSY;
                cnt   <= CW'(READ_LAT - 2);
            end
        end else if (cnt == '0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // Lane-masked store; memory contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (isStore && bus.LaneMaskM[i])
                mem[idx][i*LANE_W +: LANE_W] <= bus.WriteDataM[i*LANE_W +: LANE_W];
    end

    // M->W register: a stalled cycle inserts a bubble and holds the data fields
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ValidW     <= 1'b0;
            bus.RegWriteW  <= 1'b0;
            bus.ResultSrcW <= 1'b0;
            bus.ErrW       <= 1'b0;
            bus.ReadDataW  <= '0;
            bus.ALUResultW <= '0;
            bus.RdW        <= '0;
            bus.PCPlus4W   <= '0;
        end else if (stall) begin
            bus.ValidW    <= 1'b0;
            bus.RegWriteW <= 1'b0;
        end else begin
            bus.ValidW     <= bus.ValidM;
            bus.RegWriteW  <= bus.ValidM & bus.RegWriteM & ~errM;
            bus.ResultSrcW <= bus.ResultSrcM;
            bus.ErrW       <= errM;
            bus.ReadDataW  <= (isLoad && !errM) ? mem[idx] : '0;
            bus.ALUResultW <= bus.ALUResultM;
            bus.RdW        <= bus.RdM;
            bus.PCPlus4W   <= bus.PCPlus4M;
        end
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: drives three memory stages (READ_LAT 1, 2, 4) against an array-based reference model
module tb_mem_stage_pipe;
    localparam int LAT [3] = '{1, 2, 4};

    typedef struct packed {
        logic         validW;
        logic         regWriteW;
        logic         resultSrcW;
        logic         errW;
        logic [4:0]   rdW;
        logic [31:0]  pcW;
        logic [255:0] aluW;
        logic [255:0] readW;
    } wOut_t;

    logic         clk;
    logic         rst;
    int           sel;
    logic         vM, rwM, rsM, mwM;
    logic [7:0]   maskM;
    logic [255:0] aluM, wdM;
    logic [4:0]   rdM;
    logic [31:0]  pcM;
    logic         stallV [3];
    wOut_t        wV [3];
    logic [255:0] mMem [3][256];
    int           nVec = 0;
    int           nErr = 0;

    mem_stage_pipe_if bus [3] ();

    for (genvar k = 0; k < 3; k++) begin : g
        assign bus[k].ValidM     = vM & (sel == k || sel == 3);
        assign bus[k].RegWriteM  = rwM;
        assign bus[k].ResultSrcM = rsM;
        assign bus[k].MemWriteM  = mwM;
        assign bus[k].LaneMaskM  = maskM;
        assign bus[k].ALUResultM = aluM;
        assign bus[k].WriteDataM = wdM;
        assign bus[k].RdM        = rdM;
        assign bus[k].PCPlus4M   = pcM;
        assign stallV[k]         = bus[k].StallM;
        assign wV[k] = {bus[k].ValidW, bus[k].RegWriteW, bus[k].ResultSrcW, bus[k].ErrW,
                        bus[k].RdW, bus[k].PCPlus4W, bus[k].ALUResultW, bus[k].ReadDataW};
        mem_stage_pipe #(.READ_LAT(LAT[k])) dut (.clk(clk), .rst(rst), .bus(bus[k]));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] splat(input logic [31:0] w);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = w;
        return r;
    endfunction

    // Presents one instruction at a negedge, counts stall cycles, checks the W capture, updates the model
    task automatic issue(input int s, input logic v, input logic rw, input logic rs, input logic mw,
                         input logic [7:0] mask, input logic [255:0] alu, input logic [255:0] wd,
                         input logic [4:0] rd, input logic [31:0] pc);
        int           stalls;
        logic         ld, err;
        logic [7:0]   ix;
        logic [255:0] expRead;
        ld = v & rs & ~mw;
        ix = alu[7:0];
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        err = v & (rs | mw) & (alu[31:8] != 24'd0);
`else
        err = 1'b0;
`endif
        expRead = (ld && !err) ? mMem[s][ix] : '0;
        sel = s; vM = v; rwM = rw; rsM = rs; mwM = mw; maskM = mask;
        aluM = alu; wdM = wd; rdM = rd; pcM = pc;
        #1;
        stalls = 0;
        while (stallV[s] && stalls < 8) begin
            @(negedge clk);
            stalls++;
            chk("stall_bubble", wV[s].validW, 0);
            #1;
        end
        chk("stall_cycles", stalls, ld ? LAT[s] - 1 : 0);
        @(negedge clk);
        chk("validW", wV[s].validW, v);
        chk("regWriteW", wV[s].regWriteW, v & rw & ~err);
        chk("resultSrcW", wV[s].resultSrcW, rs);
        chk("errW", wV[s].errW, err);
        chk("rdW", wV[s].rdW, rd);
        chk("pcW", wV[s].pcW, pc);
        chk("aluW", wV[s].aluW, alu);
        chk("readW", wV[s].readW, expRead);
        if (v && mw && !err)
            for (int i = 0; i < 8; i++)
                if (mask[i]) mMem[s][ix][i*32 +: 32] = wd[i*32 +: 32];
    endtask

    initial begin
        logic [255:0] e, old0;
        rst = 1'b1;
        sel = 3;
        for (int c = 0; c < 2; c++) begin
            {vM, rwM, rsM, mwM} = 4'($urandom());
            maskM = 8'($urandom()); aluM = rnd256(); wdM = rnd256();
            rdM = 5'($urandom()); pcM = $urandom();
            @(negedge clk);
        end
        vM = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_ctl", {wV[s].validW, wV[s].regWriteW, wV[s].resultSrcW, wV[s].errW,
                              wV[s].rdW, wV[s].pcW}, 0);
            chk("reset_alu", wV[s].aluW, 0);
            chk("reset_read", wV[s].readW, 0);
            chk("reset_stall", stallV[s], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 3; s++)
            for (int a = 0; a < 256; a++)
                issue(s, 1, 0, 0, 1, 8'hff, 256'(a), rnd256(), 5'd0, 32'd0);

        issue(1, 1, 0, 0, 1, 8'hff, 256'd5, splat(32'hAAAAAAAA), 5'd0, 32'd4);
        issue(1, 1, 0, 0, 1, 8'b0000_0101, 256'd5, splat(32'h11111111), 5'd0, 32'd8);
        issue(1, 1, 1, 1, 0, 8'h00, 256'd5, rnd256(), 5'd3, 32'd12);
        for (int i = 0; i < 8; i++) e[i*32 +: 32] = (i == 0 || i == 2) ? 32'h11111111 : 32'hAAAAAAAA;
        chk("masked_load", wV[1].readW, e);

        issue(0, 1, 1, 0, 0, 8'h00, 256'h1234, rnd256(), 5'd7, 32'h40);
        chk("l1_rd", wV[0].rdW, 7);
        chk("l1_alu", wV[0].aluW, 256'h1234);
        issue(0, 1, 0, 0, 1, 8'hff, 256'd20, rnd256(), 5'd0, 32'h44);
        issue(0, 1, 1, 1, 0, 8'h00, 256'd20, rnd256(), 5'd9, 32'h48);

        issue(1, 1, 1, 1, 1, 8'hff, 256'd6, rnd256(), 5'd2, 32'h50);
        chk("ld_st_read0", wV[1].readW, 0);

        old0 = mMem[1][0];
        issue(1, 1, 1, 0, 1, 8'hff, 256'h100, splat(32'h5), 5'd1, 32'h60);
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
        chk("oob_err", wV[1].errW, 1);
        chk("oob_regwrite", wV[1].regWriteW, 0);
        e = old0;
`else
        chk("oob_err", wV[1].errW, 0);
        e = splat(32'h5);
`endif
        issue(1, 1, 1, 1, 0, 8'h00, 256'd0, rnd256(), 5'd1, 32'h64);
        chk("oob_mem0", wV[1].readW, e);

        issue(2, 1, 0, 0, 1, 8'hff, 256'd9, rnd256(), 5'd0, 32'h70);
        sel = 2; vM = 1'b1; rwM = 1'b1; rsM = 1'b1; mwM = 1'b0; aluM = 256'd9; rdM = 5'd4;
        #1;
        chk("rst_busy_stall_t", stallV[2], 1);
        @(negedge clk);
        rst = 1'b1;
        vM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy_stall_t2", stallV[2], 0);
        chk("rst_busy_valid_t2", wV[2].validW, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("rst_busy_valid", wV[2].validW, 0);
            chk("rst_busy_stall", stallV[2], 0);
        end
        @(negedge clk);
        issue(2, 1, 1, 1, 0, 8'h00, 256'd9, rnd256(), 5'd4, 32'h74);

        for (int n = 0; n < 300; n++) begin
            logic [255:0] a;
            int kind;
            kind = $urandom_range(0, 3);
            a = rnd256();
            a[31:8] = ($urandom_range(0, 7) == 0) ? 24'($urandom()) : 24'd0;
            issue($urandom_range(0, 2), $urandom_range(0, 7) != 0, 1'($urandom()),
                  kind == 1 || kind == 3, kind >= 2, 8'($urandom()), a, rnd256(),
                  5'($urandom()), $urandom());
        end

        vM = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
